// File: rtl/fsk_demodulator_if.sv
// rtl/fsk_demodulator_if.sv - FSK demodulator signal bundle: waveform in, recovered bits and status out.
interface fsk_demodulator_if;
    logic din;
    logic dout;
    logic bit_valid;
    logic lock;
    logic run_err;
    logic carrier_lost;

    modport master (
        output din,
        input  dout, bit_valid, lock, run_err, carrier_lost
    );

    modport slave (
        input  din,
        output dout, bit_valid, lock, run_err, carrier_lost
    );
endinterface

// File: rtl/fsk_demodulator.sv
// rtl/fsk_demodulator.sv - FSK run-length demodulator with ACQ/TRACK lock FSM.
// Optional majority vote on recovered symbols when FSK_DEMOD_MAJORITY_EN is defined.
module fsk_demodulator #(
    parameter int CNT_W      = 4,
    parameter int ONE_MIN    = 3,
    parameter int ONE_MAX    = 5,
    parameter int ZERO_MIN   = 7,
    parameter int ZERO_MAX   = 9,
    parameter int TIMEOUT    = 12,
    parameter int LOCK_EDGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    fsk_demodulator_if.slave  bus
);

    localparam logic [CNT_W-1:0] ONE_MIN_C  = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] ONE_MAX_C  = CNT_W'(ONE_MAX);
    localparam logic [CNT_W-1:0] ZERO_MIN_C = CNT_W'(ZERO_MIN);
    localparam logic [CNT_W-1:0] ZERO_MAX_C = CNT_W'(ZERO_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam int               GOOD_W     = $clog2(LOCK_EDGES + 1);
    localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_EDGES - 1);

    typedef enum logic {ACQ, TRACK} state_t;

    state_t             state, state_nxt;
    logic               s1, s2, s3;
    logic [CNT_W-1:0]   run_cnt;
    logic               have_ref;
    logic [GOOD_W-1:0]  good_cnt;
    logic [1:0]         bad_cnt;

    logic din_edge, is_one, is_zero, valid_run, bad_run, timeout, sym, sym_out;
    logic bit_valid_nxt, run_err_nxt, carrier_lost_nxt, lock_nxt, enter_acq;

    // Run length is the counter value just before the edge reloads it.
    always_comb begin
        din_edge  = s2 ^ s3;
        is_one    = (run_cnt >= ONE_MIN_C) && (run_cnt <= ONE_MAX_C);
        is_zero   = (run_cnt >= ZERO_MIN_C) && (run_cnt <= ZERO_MAX_C);
        valid_run = din_edge && have_ref && (is_one || is_zero);
        bad_run   = din_edge && have_ref && !(is_one || is_zero);
        timeout   = !din_edge && (run_cnt == TIMEOUT_C);
        sym       = is_one;
    end

`ifdef FSK_DEMOD_MAJORITY_EN
    // Two stored symbols plus the current one form the 3-entry vote window.
    logic [1:0] sym_hist;

    always_comb begin
        sym_out = (sym & sym_hist[0]) | (sym & sym_hist[1]) | (sym_hist[0] & sym_hist[1]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_hist <= 2'b00;
        end else if (enter_acq) begin
            sym_hist <= 2'b00;
        end else if (valid_run) begin
            sym_hist <= {sym_hist[0], sym};
        end
    end
`else
    always_comb begin
        sym_out = sym;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACQ: begin
                if (valid_run && (good_cnt == LOCK_LAST)) begin
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (timeout || (bad_run && (bad_cnt != 2'd0))) begin
                    state_nxt = ACQ;
                end
            end
            default: state_nxt = ACQ;
        endcase
    end

    always_comb begin
        bit_valid_nxt    = valid_run && (state_nxt == TRACK);
        run_err_nxt      = (state == TRACK) && bad_run;
        carrier_lost_nxt = (state == TRACK) && timeout;
        lock_nxt         = (state_nxt == TRACK);
        enter_acq        = (state == TRACK) && (state_nxt == ACQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1               <= 1'b0;
            s2               <= 1'b0;
            s3               <= 1'b0;
            run_cnt          <= '0;
            have_ref         <= 1'b0;
            good_cnt         <= '0;
            bad_cnt          <= 2'd0;
            bus.dout         <= 1'b0;
            bus.bit_valid    <= 1'b0;
            bus.lock         <= 1'b0;
            bus.run_err      <= 1'b0;
            bus.carrier_lost <= 1'b0;
        end else begin
            s1 <= bus.din;
            s2 <= s1;
            s3 <= s2;

            if (din_edge) begin
                run_cnt <= CNT_W'(1);
            end else if (run_cnt != CNT_MAX) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end

            if (din_edge) begin
                have_ref <= 1'b1;
            end else if (timeout) begin
                have_ref <= 1'b0;
            end

            if (enter_acq) begin
                good_cnt <= '0;
                bad_cnt  <= 2'd0;
            end else if (state == ACQ) begin
                if (bad_run || timeout) begin
                    good_cnt <= '0;
                end else if (valid_run) begin
                    good_cnt <= good_cnt + GOOD_W'(1);
                end
            end else begin
                if (valid_run) begin
                    bad_cnt <= 2'd0;
                end else if (bad_run) begin
                    bad_cnt <= bad_cnt + 2'd1;
                end
            end

            if (bit_valid_nxt) begin
                bus.dout <= sym_out;
            end
            bus.bit_valid    <= bit_valid_nxt;
            bus.lock         <= lock_nxt;
            bus.run_err      <= run_err_nxt;
            bus.carrier_lost <= carrier_lost_nxt;
        end
    end

endmodule

// File: tb/tb_fsk_demodulator.sv
// tb/tb_fsk_demodulator.sv - directed table-driven bench for fsk_demodulator.
module tb_fsk_demodulator;

    localparam int EV_NONE = 0;
    localparam int EV_BIT  = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_LOST = 3;

`ifdef FSK_DEMOD_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    // One record per din toggle: hold length before it, and the event its run must produce.
    typedef struct {
        int len;
        int kind;
        int val;
        int lk;
    } vec_t;

    typedef struct {
        int kind;
        int val;
        int lk;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    vec_t tab[$];
    ev_t  evlog[$];

    fsk_demodulator_if bus ();

    fsk_demodulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.bit_valid)    evlog.push_back('{EV_BIT, int'(bus.dout), int'(bus.lock), cyc});
            if (bus.run_err)      evlog.push_back('{EV_ERR, 0, int'(bus.lock), cyc});
            if (bus.carrier_lost) evlog.push_back('{EV_LOST, 0, int'(bus.lock), cyc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dout"},         int'(bus.dout), 0);
        chk({tag, "_bit_valid"},    int'(bus.bit_valid), 0);
        chk({tag, "_lock"},         int'(bus.lock), 0);
        chk({tag, "_run_err"},      int'(bus.run_err), 0);
        chk({tag, "_carrier_lost"}, int'(bus.carrier_lost), 0);
    endtask

    function automatic void add(input int len, input int kind, input int val, input int lk);
        tab.push_back('{len, kind, val, lk});
    endfunction

    task automatic apply_tab(input string tag);
        int k;
        int prev_cyc;
        for (int i = 0; i < tab.size(); i++) begin
            repeat (tab[i].len) @(posedge clk);
            #1 bus.din = ~bus.din;
        end
        repeat (6) @(posedge clk);
        #1;
        k = 0;
        prev_cyc = 0;
        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].kind != EV_NONE) begin
                if (k < evlog.size()) begin
                    chk($sformatf("%s_kind_%0d", tag, i), evlog[k].kind, tab[i].kind);
                    chk($sformatf("%s_lock_%0d", tag, i), evlog[k].lk, tab[i].lk);
                    if (tab[i].kind == EV_BIT)
                        chk($sformatf("%s_dout_%0d", tag, i), evlog[k].val, tab[i].val);
                    if (i > 0 && tab[i].kind == EV_BIT && tab[i-1].kind == EV_BIT)
                        chk($sformatf("%s_gap_%0d", tag, i), evlog[k].cyc - prev_cyc, tab[i].len);
                    prev_cyc = evlog[k].cyc;
                end else begin
                    chk($sformatf("%s_missing_%0d", tag, i), evlog.size(), k + 1);
                end
                k++;
            end
        end
        chk({tag, "_event_count"}, evlog.size(), k);
    endtask

    initial begin
        bus.din = 1'b0;
        rst = 1'b0;
        #23;
        chk_idle("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Reference edge, 4/4 lock, then TRACK with mixed runs.
        add(3, EV_NONE, 0, 0);
        add(4, EV_NONE, 0, 0);
        add(4, EV_NONE, 0, 0);
        add(4, EV_NONE, 0, 0);
        add(4, EV_BIT, 1, 1);
        add(4, EV_BIT, 1, 1);
        add(4, EV_BIT, 1, 1);
        add(4, EV_BIT, 1, 1);
        add(4, EV_BIT, 1, 1);
        add(8, EV_BIT, MAJ ? 1 : 0, 1);
        add(8, EV_BIT, 0, 1);
        add(4, EV_BIT, MAJ ? 0 : 1, 1);
        add(4, EV_BIT, 1, 1);
        // Short glitches: lone error keeps lock, two in a row drop it.
        add(1, EV_ERR, 0, 1);
        add(4, EV_BIT, 1, 1);
        add(2, EV_ERR, 0, 1);
        add(2, EV_ERR, 0, 0);
        // 8/8 relock using the still-valid reference.
        add(8, EV_NONE, 0, 0);
        add(8, EV_NONE, 0, 0);
        add(8, EV_NONE, 0, 0);
        add(8, EV_BIT, 0, 1);
        add(8, EV_BIT, 0, 1);
        add(8, EV_BIT, 0, 1);
        // Silent carrier: one loss pulse; the terminating toggle is a fresh reference.
        add(20, EV_LOST, 0, 0);
        add(4, EV_NONE, 0, 0);
        add(4, EV_NONE, 0, 0);
        add(4, EV_NONE, 0, 0);
        add(4, EV_BIT, 1, 1);
        add(4, EV_BIT, 1, 1);
        apply_tab("main");
        chk("main_locked_before_reset", int'(bus.lock), 1);
        chk("main_dout_before_reset", int'(bus.dout), 1);

        // Asynchronous reset mid-run while locked.
        #2 rst = 1'b0;
        bus.din = 1'b0;
        #1;
        chk_idle("async_reset");
        evlog.delete();
        tab.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        add(3, EV_NONE, 0, 0);
        add(8, EV_NONE, 0, 0);
        add(8, EV_NONE, 0, 0);
        add(8, EV_NONE, 0, 0);
        add(8, EV_BIT, 0, 1);
        add(8, EV_BIT, 0, 1);
        apply_tab("relock");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
